cache_arbiter: RTL
==================

// Module: cache_arbiter
// PURPOSE
//  Shares the single physical-memory port between the I-cache and D-cache controllers.
//  Sits between both caches' pmem-side interfaces and main memory.
//  Grants one cache line transaction at a time, with round-robin tie-breaking.
//  Latches the granted command so memory sees a stable request.
//  Keeps saturating per-requester grant counters for performance analysis.
// PARAMETERS
//  ADDR_W  32   pmem address width
//  LINE_W  256  cache line width (rdata/wdata)
//  CNT_W   16   width of each grant counter
// PORTS
//  clk             in   1       clock; all state updates on posedge
//  rst             in   1       synchronous reset, active-high
//  i_pmem_read     in   1       I-cache line-fill request
//  i_pmem_address  in   ADDR_W  I-cache line address
//  i_pmem_rdata    out  LINE_W  line data to I-cache
//  i_pmem_resp     out  1       I-cache transaction complete
//  d_pmem_read     in   1       D-cache line-fill request
//  d_pmem_write    in   1       D-cache write-back request
//  d_pmem_address  in   ADDR_W  D-cache line address
//  d_pmem_wdata    in   LINE_W  D-cache write-back data
//  d_pmem_rdata    out  LINE_W  line data to D-cache
//  d_pmem_resp     out  1       D-cache transaction complete
//  pmem_read       out  1       read command to memory
//  pmem_write      out  1       write command to memory
//  pmem_address    out  ADDR_W  address to memory
//  pmem_wdata      out  LINE_W  write data to memory
//  pmem_rdata      in   LINE_W  read data from memory
//  pmem_resp       in   1       memory transaction complete
//  busy            out  1       1 while in SERVE_I or SERVE_D
//  i_grant_cnt     out  CNT_W   completed I transactions, saturating
//  d_grant_cnt     out  CNT_W   completed D transactions, saturating
// BEHAVIOUR
//  Reset
//   - state=IDLE, last_grant=I (D wins the first tie).
//   - Command regs, pmem_read/pmem_write, counters all 0.
//  FSM states: IDLE, SERVE_I, SERVE_D.
//  IDLE
//   - pmem_read=pmem_write=0.
//   - Exactly one requester active -> grant it.
//   - Both active -> grant the one != last_grant.
//   - On grant: latch that requester's read/write/address/wdata; go to SERVE_x next cycle.
//   - No requester active -> stay in IDLE.
//  SERVE_x
//   - pmem_read/write/address/wdata driven from the latched regs only.
//   - Requester input changes after grant are ignored.
//   - Command is held every cycle until pmem_resp.
//  Completion
//   - pmem_resp=1 in SERVE_x -> x_pmem_resp=1 in the same cycle (combinational).
//   - Next cycle: state=IDLE, last_grant=x, x_grant_cnt+1 (holds at all-ones).
//   - pmem_resp in IDLE is ignored; no resp is forwarded.
//  Data return
//   - pmem_rdata is routed to both i_/d_pmem_rdata; only the owner's resp is asserted.
//   - Non-owner resp is always 0.
//  Latency and throughput
//   - Request seen in cycle t -> command at memory in t+1.
//   - Resp in cycle r -> arbiter back in IDLE at r+1 -> next command earliest at r+2.
//   - A request still high at r+1 is treated as a new request.
//  D request with read and write both high: write wins; only pmem_write is latched.
//  Reset mid-transaction
//   - Command drops the next cycle; no x_resp is forwarded; counters clear.
//   - A late pmem_resp is ignored.
// TESTING
//  1. I read 0x100, mem resp after 3 cycles
//     -> pmem_read=1 addr 0x100 from t+1; i_resp with rdata; i_cnt=1; d_resp stays 0.
//  2. D write 0x200, wdata=pattern A
//     -> pmem_write=1 with wdata A held until resp; d_cnt=1.
//  3. I and D request together from reset
//     -> D served first, I at r+2; counts 1/1.
//  4. D write-back then immediate D read, I waiting
//     -> order D-write, I-read, D-read (round robin).
//  5. rst asserted during SERVE_D, pmem_resp pulses the next cycle
//     -> no d_resp; state IDLE; counters 0.
//  6. CNT_W=2, 5 I transactions -> i_grant_cnt saturates at 3.
//     Change i_pmem_address after grant -> pmem_address unchanged.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory pmem signals seen by the arbiter.
// slave is the arbiter's view; master is the caches-plus-memory side.
interface cache_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between I-cache and D-cache,
// holding the granted command stable and counting completed grants per requester.
module cache_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_arbiter_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } cmd_t;

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic             last_d_q, last_d_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;

  logic i_req, d_req, pick_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // On a tie the requester that did not win last time is chosen.
  assign i_req  = bus.i_pmem_read;
  assign d_req  = bus.d_pmem_read | bus.d_pmem_write;
  assign pick_d = d_req & (~i_req | ~last_d_q);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    last_d_d = last_d_q;
    i_cnt_d  = i_cnt_q;
    d_cnt_d  = d_cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = SERVE_D;
          cmd_d.write = bus.d_pmem_write;
          cmd_d.read  = bus.d_pmem_read & ~bus.d_pmem_write;
          cmd_d.addr  = bus.d_pmem_address;
          cmd_d.wdata = bus.d_pmem_wdata;
        end else if (i_req) begin
          state_d     = SERVE_I;
          cmd_d.write = 1'b0;
          cmd_d.read  = 1'b1;
          cmd_d.addr  = bus.i_pmem_address;
          cmd_d.wdata = '0;
        end
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          state_d     = IDLE;
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
          last_d_d    = 1'b0;
          i_cnt_d     = sat_inc(i_cnt_q);
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          state_d     = IDLE;
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
          last_d_d    = 1'b1;
          d_cnt_d     = sat_inc(d_cnt_q);
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_d.read  = 1'b0;
        cmd_d.write = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Synchronous reset; last_d_q=0 means I won last, so D takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      last_d_q <= 1'b0;
      busy_q   <= 1'b0;
      i_cnt_q  <= '0;
      d_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      last_d_q <= last_d_d;
      busy_q   <= busy_d;
      i_cnt_q  <= i_cnt_d;
      d_cnt_q  <= d_cnt_d;
    end
  end

  assign bus.pmem_read    = cmd_q.read;
  assign bus.pmem_write   = cmd_q.write;
  assign bus.pmem_address = cmd_q.addr;
  assign bus.pmem_wdata   = cmd_q.wdata;

  // Data fans out to both caches; only the owner sees resp, and never during reset.
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;
  assign bus.i_pmem_resp  = (state_q == SERVE_I) & bus.pmem_resp & ~rst;
  assign bus.d_pmem_resp  = (state_q == SERVE_D) & bus.pmem_resp & ~rst;

  assign busy        = busy_q;
  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

endmodule
